// File: rtl/lfsr_burst_ctrl_if.sv
// Bus between the LFSR burst controller and its environment: two requesters
// with a level request / word accept pair each, plus the serial generator link.
//
// Handshake: the controller raises gnt[i] when it picks requester i and holds it
// until the word is taken; valid[i] rises once dout holds a complete word and
// stays high, with dout stable, until an edge where ack[i] is sampled high for
// the granted bit. ack bits of a non-granted requester, or ack outside a word
// offer, have no effect.
interface lfsr_burst_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic [1:0]       req;
  logic [1:0]       ack;
  logic [1:0]       gnt;
  logic [1:0]       valid;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             lock_err;
  logic             lfsr_load;
  logic             lfsr_seed;
  logic             lfsr_q;
  logic [1:0]       dbg_state;

  // Requester / generator side.
  modport master (
    output req, ack, lfsr_q,
    input  gnt, valid, dout, busy, lock_err, lfsr_load, lfsr_seed, dbg_state
  );

  // Controller side.
  modport slave (
    input  req, ack, lfsr_q,
    output gnt, valid, dout, busy, lock_err, lfsr_load, lfsr_seed, dbg_state
  );
endinterface

// File: rtl/lfsr_burst_ctrl.sv
// LFSR burst controller: shares one free-running 4-bit serial LFSR between two
// requesters. It seeds the generator, collects WIDTH serial samples into a word
// and offers the word to the granted requester with a valid/ack handshake.
// Round-robin arbitration and a lock-up watchdog (four consecutive zero samples)
// are included.
//
// Build option: define LFSR_CTRL_RESEED_EN to reseed the generator before every
// burst, giving the same word each time. Without it, the generator is seeded
// only after reset or a watchdog trip.
module lfsr_burst_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clock,
  input  logic              rst,
  lfsr_burst_ctrl_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEED  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef LFSR_CTRL_RESEED_EN
  localparam logic RESEED_ALWAYS = 1'b1;
`else
  localparam logic RESEED_ALWAYS = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       valid_q, valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       zc_q, zc_d;
  logic             busy_q, busy_d;
  logic             lock_err_q, lock_err_d;
  logic             load_q, load_d;
  logic             ptr_q, ptr_d;
  logic             seeded_q, seeded_d;
  logic [1:0]       pick;
  logic             trip;

  // Next-state logic: arbitration, seeding, sampling, watchdog and handshake.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    valid_d    = valid_q;
    dout_d     = dout_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    zc_d       = zc_q;
    lock_err_d = lock_err_q;
    load_d     = 1'b0;
    ptr_d      = ptr_q;
    seeded_d   = seeded_q;

    // Both requesting: the pointer decides; otherwise the lone requester wins.
    if (bus.req == 2'b11) begin
      pick = ptr_q ? 2'b10 : 2'b01;
    end else begin
      pick = bus.req;
    end

    // Fourth zero in a row means the generator is stuck in its all-zero state.
    trip = (state_q == S_SHIFT) && !bus.lfsr_q && (zc_q == 2'd3);

    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          gnt_d  = pick;
          cnt_d  = '0;
          word_d = '0;
          // Each burst counts zeros from scratch; bursts are not contiguous
          // stretches of the generator sequence.
          zc_d   = 2'd0;
          if (!seeded_q || RESEED_ALWAYS) begin
            state_d = S_SEED;
            load_d  = 1'b1;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SEED: begin
        seeded_d = 1'b1;
        cnt_d    = '0;
        zc_d     = 2'd0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        if (trip) begin
          // Drop the partial word and reseed; the grant is kept.
          lock_err_d = 1'b1;
          seeded_d   = 1'b0;
          zc_d       = 2'd0;
          cnt_d      = '0;
          word_d     = '0;
          load_d     = 1'b1;
          state_d    = S_SEED;
        end else begin
          zc_d   = bus.lfsr_q ? 2'd0 : zc_q + 2'd1;
          word_d = {word_q[WIDTH-2:0], bus.lfsr_q};
          if (cnt_q == CW'(WIDTH - 1)) begin
            dout_d  = word_d;
            valid_d = gnt_q;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (|(bus.ack & gnt_q)) begin
          // Favour the other requester next: serving 0 sets the pointer to 1.
          ptr_d   = gnt_q[0];
          gnt_d   = 2'b00;
          valid_d = 2'b00;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 2'b00;
      valid_q    <= 2'b00;
      dout_q     <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      zc_q       <= 2'd0;
      busy_q     <= 1'b0;
      lock_err_q <= 1'b0;
      load_q     <= 1'b0;
      ptr_q      <= 1'b0;
      seeded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      valid_q    <= valid_d;
      dout_q     <= dout_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      zc_q       <= zc_d;
      busy_q     <= busy_d;
      lock_err_q <= lock_err_d;
      load_q     <= load_d;
      ptr_q      <= ptr_d;
      seeded_q   <= seeded_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.valid     = valid_q;
  assign bus.dout      = dout_q;
  assign bus.busy      = busy_q;
  assign bus.lock_err  = lock_err_q;
  assign bus.lfsr_load = load_q;
  assign bus.lfsr_seed = 1'b1;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/lfsr_burst_ctrl.md
# lfsr_burst_ctrl

Controller that sequences the 4-bit serial LFSR generator and shares it between two requesters. It seeds the generator, samples its serial output into WIDTH-bit random words, and delivers each word to the granted requester with a valid/ack handshake. Round-robin arbitration and a lock-up watchdog sit between the requesters and the generator.

## Interface
- WIDTH, 8, bits per delivered word (2..16)
- clock  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  2  per-requester burst request, level
- ack  in  2  per-requester word accept; only the granted bit is honoured
- gnt  out  2  one-hot grant, held from arbitration until ack
- valid  out  2  one-hot word valid, bit = granted requester
- dout  out  WIDTH  random word, stable while valid
- busy  out  1  high in any state except IDLE
- lock_err  out  1  sticky lock-up flag
- lfsr_load  out  1  to generator load
- lfsr_seed  out  1  to generator seed; driven 1 always
- lfsr_q  in  1  generator serial output

## Operation
- Generator contract: on a clock edge with load=1, all 4 stages take seed. Otherwise state s becomes {s[2:0], q}, where q = s[3]^s[2] (combinational). Generator free-runs; it cannot be paused. From 1111 the q sequence (period 15) is 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1.
- States:
  - IDLE: if any req, pick requester, latch gnt, go SEED if reseed needed, else SHIFT.
  - SEED: lfsr_load=1 for exactly one cycle, set seeded flag, go SHIFT.
  - SHIFT: sample lfsr_q on WIDTH consecutive edges; word shifts in at LSB: w <= {w[WIDTH-2:0], lfsr_q}. After the WIDTH-th sample, go DONE.
  - DONE: valid[g]=1, dout=w. On ack[g], clear gnt/valid and return to IDLE.
- Reseed needed: seeded flag is 0 (after reset or watchdog), or the reseed feature is compiled in.
- Arbitration: round-robin with a 1-bit pointer. It favours requester 0 after reset, and after serving requester i it favours the other. A lone requester is served back-to-back.
- Watchdog: counts consecutive zero samples in SHIFT (a legal sequence has at most 3).
  - On the 4th consecutive zero: set lock_err (sticky until rst), clear the seeded flag, discard the partial word, go SEED, then restart the full WIDTH-bit burst for the same grant.
  - The counter clears on any 1 sample and on entering SEED.
- Grant stability: a req drop after grant does not abort the burst; the word is still delivered and held until ack. ack on a non-granted bit, or outside DONE, is ignored.
- ack and req in the same cycle: the requester is re-arbitrated in IDLE next cycle, and the pointer already favours the other requester.

## Timing
- Reset values: gnt=0, valid=0, dout=0, busy=0, lock_err=0, lfsr_load=0, lfsr_seed=1, pointer=0, seeded=0, state IDLE.
- Async reset mid-burst: everything returns to reset values immediately; any word in flight is lost.
- Latency with SEED (edge E = IDLE edge seeing req):
  - gnt high after E.
  - lfsr_load high in the cycle after E.
  - First sample at E+2.
  - valid high after edge E+WIDTH+1.
- Latency without SEED: valid high after edge E+WIDTH.
- ack seen at edge A: valid/gnt low after A, IDLE during the next cycle, earliest next grant at A+1.
- Outputs are registered except lfsr_seed, which is constant.

## Configuration
- LFSR_CTRL_RESEED_EN defined: SEED runs before every burst. Every word equals the first WIDTH q bits from 1111 (WIDTH=8 gives 0x13), independent of request timing.
- Not defined: SEED runs only after reset or a watchdog trip. The generator free-runs between bursts, and words depend on the cycle gaps between bursts.

## Test plan
- Reset, WIDTH=8, RESEED_EN defined, req=01 held, ack the same cycle as valid:
  - valid=01 rises 10 edges after the first IDLE edge, dout=0x13.
  - Repeated bursts all give 0x13, one per 11 cycles.
- req=11 continuously, RESEED_EN: grants alternate 01,10,01,10; every dout=0x13; no requester is served twice in a row.
- RESEED_EN undefined, req=01, ack asserted 1 cycle after valid: first dout=0x13; second dout equals the bench reference model of the free-running generator, not 0x13.
- Bench stub forces lfsr_q=0 mid-SHIFT:
  - lock_err rises on the 4th zero sample, then lfsr_load pulses once.
  - After the stub releases to a real generator, the delivered word is 0x13 and lock_err stays 1.
- req=10 granted, then req dropped and ack=01 driven in DONE: valid stays 10 and dout is held; ack=10 completes.
- rst pulsed during SHIFT: gnt, valid, busy and lock_err go to 0 immediately; the next burst re-enters SEED.
